exc_ctrl: RTL and testbench

Exception request controller for the single-cycle ARMv8 core with exceptions: the initiating side of the Exc/ExcAck/ERet handshake into the exception unit. It collects external interrupt lines and the decoder's invalid-opcode flag, prioritises them, and raises `Exc` with a 4-bit `EStatus` cause code. It holds the request until the exception unit acknowledges the vector fetch, then blocks further requests until the handler executes `ERET`.

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_ctrl_irq_sync.sv | 34 +++
 rtl/exc_ctrl.sv | 130 +++++++++++++
 tb/tb_exc_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception request controller.
//   state_t      - controller FSM states (IDLE, REQ, SERVICE)
//   EST_*        - EStatus cause codes
//   N_IRQ_MAX    - largest supported number of external interrupt lines
package exc_pkg;

    localparam int N_IRQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] EST_NONE     = 4'h0;
    localparam logic [3:0] EST_BADOP    = 4'h1;
    localparam logic [3:0] EST_IRQ_BASE = 4'h8;

    // Cause code for an external line: IRQ i reports 4'h8 + i.
    function automatic logic [3:0] irq_code(input int idx);
        return EST_IRQ_BASE | 4'(idx);
    endfunction

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// irq_sync: brings one asynchronous interrupt line into the clk domain
// through two flops, then flags a rising edge for one cycle.
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   irq_async in   raw external interrupt line
//   rise      out  one-cycle pulse after a synchronised 0->1 transition
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq_async,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= irq_async;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // Only sync2 and its delayed copy are compared, so sync1 (possibly
    // metastable) never feeds logic directly.
    assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: initiating side of the Exc/ExcAck/ERet exception handshake.
// Collects external interrupt edges and the invalid-opcode flag into a
// pending register, picks the highest-priority selectable cause, raises Exc
// with the cause in EStatus, and blocks further requests until ERET.
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   ExtIRQ     in   asynchronous external interrupt lines (rising edge = request)
//   IrqMask    in   1 = line masked (edges still latch pending)
//   BadOpcode  in   decoder invalid-instruction flag
//   ExcAck     in   exception unit has reached the vector
//   ERet       in   ERET retiring this cycle
//   Exc        out  exception request
//   EStatus    out  cause code of current/last request
//   InService  out  handler running
//   Pending    out  pending bits: [0] BadOpcode, [i+1] ExtIRQ[i]
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] ExtIRQ,
    input  logic [N_IRQ-1:0] IrqMask,
    input  logic             BadOpcode,
    input  logic             ExcAck,
    input  logic             ERet,
    output logic             Exc,
    output logic [3:0]       EStatus,
    output logic             InService,
    output logic [N_IRQ:0]   Pending
);

    localparam int NP = N_IRQ + 1;

    state_t          state_reg, state_next;
    logic [3:0]      est_reg, est_next;
    logic [NP-1:0]   cause_reg, cause_next;    // one-hot pending bit of the request
    logic [NP-1:0]   pending_reg, pending_next;
    logic [N_IRQ-1:0] irq_rise;
    logic [NP-1:0]   selectable;
    logic [NP-1:0]   pend_clr;
    logic [3:0]      pick_code;
    logic [NP-1:0]   pick_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_sync
            irq_sync u_sync (
                .clk       (clk),
                .reset     (reset),
                .irq_async (ExtIRQ[gi]),
                .rise      (irq_rise[gi])
            );
        end
    endgenerate

    // Bit 0 (invalid opcode) cannot be masked.
    assign selectable = pending_reg & {~IrqMask, 1'b1};

    // Priority: scan from the highest index down so the lowest set bit is
    // the last to overwrite, then let the invalid opcode override.
    always_comb begin
        pick_code   = EST_NONE;
        pick_onehot = '0;
        for (int i = N_IRQ; i >= 1; i--) begin
            if (selectable[i]) begin
                pick_code      = irq_code(i - 1);
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
            end
        end
        if (selectable[0]) begin
            pick_code   = EST_BADOP;
            pick_onehot = '0;
            pick_onehot[0] = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        est_next   = est_reg;
        cause_next = cause_reg;
        pend_clr   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (|selectable) begin
                    state_next = ST_REQ;
                    est_next   = pick_code;
                    cause_next = pick_onehot;
                end
            end
            ST_REQ: begin
                // The request is held regardless of later mask changes.
                if (ExcAck) begin
                    pend_clr   = cause_reg;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (ERet) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // New events win over an acknowledge of the same bit.
        pending_next = (pending_reg & ~pend_clr) | {irq_rise, BadOpcode};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            est_reg     <= EST_NONE;
            cause_reg   <= '0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            est_reg     <= est_next;
            cause_reg   <= cause_next;
            pending_reg <= pending_next;
        end
    end

    assign Exc       = (state_reg == ST_REQ);
    assign InService = (state_reg == ST_SERVICE);
    assign EStatus   = est_reg;
    assign Pending   = pending_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ext, mask;
    logic         badop, ack, eret;
    logic         exc, insvc;
    logic [3:0]   est;
    logic [N:0]   pend;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(.N_IRQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .ExtIRQ    (ext),
        .IrqMask   (mask),
        .BadOpcode (badop),
        .ExcAck    (ack),
        .ERet      (eret),
        .Exc       (exc),
        .EStatus   (est),
        .InService (insvc),
        .Pending   (pend)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Mode: 0 waiting, 1 requesting, 2 handler running.
    int         m_mode;
    int         m_cause;
    logic [3:0] m_est;
    logic [N:0] m_pend;
    logic [N-1:0] h0, h1, h2, h3;   // ExtIRQ as seen at the last four edges

    task automatic model_reset();
        m_mode = 0; m_cause = 0; m_est = 4'h0; m_pend = '0;
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    endtask

    task automatic model_step();
        logic [N:0] sel, clr;
        int idx;
        sel = m_pend & {~mask, 1'b1};
        clr = '0;
        if (m_mode == 0) begin
            idx = -1;
            for (int i = N; i >= 0; i--) if (sel[i]) idx = i;
            if (idx >= 0) begin
                m_cause = idx;
                m_est   = (idx == 0) ? 4'h1 : 4'(8 + idx - 1);
                m_mode  = 1;
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                clr[m_cause] = 1'b1;
                m_mode = 2;
            end
        end else if (eret) begin
            m_mode = 0;
        end
        h3 = h2; h2 = h1; h1 = h0; h0 = ext;
        // A line high at edge k and low at edge k-1 becomes pending at k+2.
        m_pend = (m_pend & ~clr) | {h2 & ~h3, badop};
    endtask

    function automatic logic [10:0] model_out();
        return {m_mode == 1, m_mode == 2, m_est, m_pend};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual={exc,insvc,est,pend}=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ":model"}, {exc, insvc, est, pend}, model_out());
        $display("%s t=%0t in b=%b e=%h m=%h a=%b r=%b -> exc=%b svc=%b est=%h pend=%h",
                 tag, $time, badop, ext, mask, ack, eret, exc, insvc, est, pend);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic         b;
        logic [N-1:0] e, m;
        logic         a, r;
        logic         x_exc, x_svc;
        logic [3:0]   x_est;
        logic [N:0]   x_pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic b, input logic [3:0] e, input logic [3:0] m,
                       input logic a, input logic r, input logic x_exc, input logic x_svc,
                       input logic [3:0] x_est, input logic [4:0] x_pend);
        vec_t v;
        v.b = b; v.e = e; v.m = m; v.a = a; v.r = r;
        v.x_exc = x_exc; v.x_svc = x_svc; v.x_est = x_est; v.x_pend = x_pend;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        badop = 0; ext = '0; mask = '0; ack = 0; eret = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("in_reset", {exc, insvc, est, pend}, 11'd0);
        @(negedge clk);
        reset = 1'b1;

        // Quiet period after reset.
        for (int i = 0; i < 20; i++) begin
            tick("quiet");
            check("quiet_const", {exc, insvc, est, pend}, 11'd0);
        end

        // Invalid opcode round trip.
        add(1,4'h0,4'h0,0,0, 0,0,4'h0,5'h01);
        add(0,4'h0,4'h0,0,0, 1,0,4'h1,5'h01);
        add(0,4'h0,4'h0,0,0, 1,0,4'h1,5'h01);
        add(0,4'h0,4'h0,1,0, 0,1,4'h1,5'h00);
        add(0,4'h0,4'h0,0,0, 0,1,4'h1,5'h00);
        add(0,4'h0,4'h0,0,1, 0,0,4'h1,5'h00);
        add(0,4'h0,4'h0,0,0, 0,0,4'h1,5'h00);
        // IRQ0 and IRQ2 together: IRQ0 first, then IRQ2.
        add(0,4'h5,4'h0,0,0, 0,0,4'h1,5'h00);
        add(0,4'h5,4'h0,0,0, 0,0,4'h1,5'h00);
        add(0,4'h5,4'h0,0,0, 0,0,4'h1,5'h0A);
        add(0,4'h5,4'h0,0,0, 1,0,4'h8,5'h0A);
        add(0,4'h5,4'h0,1,0, 0,1,4'h8,5'h08);
        add(0,4'h0,4'h0,0,1, 0,0,4'h8,5'h08);
        add(0,4'h0,4'h0,0,0, 1,0,4'hA,5'h08);
        add(0,4'h0,4'h0,1,0, 0,1,4'hA,5'h00);
        add(0,4'h0,4'h0,0,1, 0,0,4'hA,5'h00);
        // Masked IRQ1 latches pending, is served once unmasked.
        add(0,4'h2,4'h2,0,0, 0,0,4'hA,5'h00);
        add(0,4'h2,4'h2,0,0, 0,0,4'hA,5'h00);
        add(0,4'h2,4'h2,0,0, 0,0,4'hA,5'h04);
        add(0,4'h2,4'h2,0,0, 0,0,4'hA,5'h04);
        add(0,4'h0,4'h0,0,0, 1,0,4'h9,5'h04);
        add(0,4'h0,4'h0,1,0, 0,1,4'h9,5'h00);
        add(0,4'h0,4'h0,0,1, 0,0,4'h9,5'h00);
        // BadOpcode and IRQ3 arrive during SERVICE: no nesting.
        add(1,4'h0,4'h0,0,0, 0,0,4'h9,5'h01);
        add(0,4'h0,4'h0,0,0, 1,0,4'h1,5'h01);
        add(0,4'h0,4'h0,1,0, 0,1,4'h1,5'h00);
        add(1,4'h8,4'h0,0,0, 0,1,4'h1,5'h01);
        add(0,4'h8,4'h0,0,0, 0,1,4'h1,5'h01);
        add(0,4'h8,4'h0,0,0, 0,1,4'h1,5'h11);
        add(0,4'h0,4'h0,0,0, 0,1,4'h1,5'h11);
        add(0,4'h0,4'h0,0,1, 0,0,4'h1,5'h11);
        add(0,4'h0,4'h0,0,0, 1,0,4'h1,5'h11);
        add(0,4'h0,4'h0,1,0, 0,1,4'h1,5'h10);
        add(0,4'h0,4'h0,0,1, 0,0,4'h1,5'h10);
        add(0,4'h0,4'h0,0,0, 1,0,4'hB,5'h10);
        add(0,4'h0,4'h0,1,0, 0,1,4'hB,5'h00);
        add(0,4'h0,4'h0,0,1, 0,0,4'hB,5'h00);

        foreach (tbl[i]) begin
            badop = tbl[i].b; ext = tbl[i].e; mask = tbl[i].m;
            ack = tbl[i].a; eret = tbl[i].r;
            tick("vec");
            check($sformatf("vec%0d", i), {exc, insvc, est, pend},
                  {tbl[i].x_exc, tbl[i].x_svc, tbl[i].x_est, tbl[i].x_pend});
        end
        idle_inputs();
        tick("vec_tail");

        // Reset while requesting: everything clears without a clock edge.
        ext = 4'h1;
        tick("rq"); tick("rq"); tick("rq");
        badop = 1;
        tick("rq");
        badop = 0;
        check("rq_before_reset", {exc, insvc, est, pend}, {1'b1, 1'b0, 4'h8, 5'h03});
        #2 reset = 1'b0;
        #1 check("async_reset", {exc, insvc, est, pend}, 11'd0);
        ext = '0; ack = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        tick("ack_after_reset");
        check("ack_after_reset_const", {exc, insvc, est, pend}, 11'd0);
        ack = 0;
        tick("post_reset");

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            for (int j = 0; j < N; j++)
                if ($urandom_range(5) == 0) ext[j] = ~ext[j];
            badop = ($urandom_range(9) == 0);
            if ($urandom_range(7) == 0) mask = N'($urandom);
            ack  = ($urandom_range(2) == 0);
            eret = ($urandom_range(3) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
